ddi_phase_scheduler: RTL

Arbitrates vehicle-detector requests from the four DDI signal phases and hands one phase at a time to the phase controller through the 2-bit priority input. It uses fixed priority, with phase 0 (mainline crossover) highest, plus an aging override so that no pending phase is starved. It also sequences entry into and exit from maintenance mode between phases. It sits upstream of the phase, timing and light controllers and receives the phase-completion pulse back from them.

---
 rtl/ddi_phase_scheduler_if.sv | 23 ++
 rtl/ddi_phase_scheduler.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ddi_phase_scheduler_if.sv
// Handshake bundle between the DDI phase scheduler and its detector and phase-controller neighbours.
// The master side is the scheduler; the slave side is the detectors plus the downstream controllers.
interface ddi_phase_scheduler_if;
  logic [3:0] det_req;
  logic       grant_ack;
  logic       phase_done;
  logic       maint_req;
  logic       grant_valid;
  logic [1:0] grant_phase;
  logic [3:0] pending;
  logic       starve_flag;
  logic       maintenance;

  modport master (
    input  det_req, grant_ack, phase_done, maint_req,
    output grant_valid, grant_phase, pending, starve_flag, maintenance
  );

  modport slave (
    output det_req, grant_ack, phase_done, maint_req,
    input  grant_valid, grant_phase, pending, starve_flag, maintenance
  );
endinterface

// File: rtl/ddi_phase_scheduler.sv
// Fixed-priority DDI phase arbiter with an aging override and maintenance sequencing.
// Phase 0 wins by default; a phase that has lost AGE_LIMIT grants is forced next.
module ddi_phase_scheduler #(
  parameter  int AGE_LIMIT = 8,
  localparam int AGE_W     = $clog2(AGE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  ddi_phase_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_MAINT  = 2'd3
  } state_t;

  state_t           state_r;
  logic [3:0]       pending_r;
  logic [AGE_W-1:0] age_r [4];
  logic             grant_valid_r;
  logic [1:0]       grant_phase_r;
  logic             starve_flag_r;
  logic             maintenance_r;

  logic [3:0]       aged_s;
  logic [1:0]       win_s;
  logic             starve_s;
  logic [3:0]       clr_s;
  logic [3:0]       pending_next_s;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Winner selection: aged pending phases override plain fixed priority.
  always_comb begin
    aged_s   = 4'b0000;
    win_s    = 2'd0;
    starve_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      aged_s[i] = pending_r[i] && (age_r[i] >= AGE_W'(AGE_LIMIT));
    end
    if (aged_s != 4'b0000) begin
      win_s    = lowest_idx(aged_s);
      starve_s = 1'b1;
    end else begin
      win_s    = lowest_idx(pending_r);
      starve_s = 1'b0;
    end
  end

  // Pending latch next value; a new request in the accept cycle outranks the clear.
  always_comb begin
    clr_s = 4'b0000;
    if ((state_r == ST_OFFER) && bus.grant_ack) begin
      clr_s = 4'b0001 << grant_phase_r;
    end else begin
      clr_s = 4'b0000;
    end
    pending_next_s = (pending_r & ~clr_s) | bus.det_req;
  end

  // Scheduler state machine with registered grant outputs, pending latch and age counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      pending_r     <= 4'b0000;
      grant_valid_r <= 1'b0;
      grant_phase_r <= 2'd0;
      starve_flag_r <= 1'b0;
      maintenance_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        age_r[i] <= '0;
      end
    end else begin
      pending_r <= pending_next_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.maint_req) begin
            state_r       <= ST_MAINT;
            maintenance_r <= 1'b1;
          end else if (pending_r != 4'b0000) begin
            state_r       <= ST_OFFER;
            grant_phase_r <= win_s;
            grant_valid_r <= 1'b1;
            starve_flag_r <= starve_s;
          end
        end
        ST_OFFER: begin
          if (bus.grant_ack) begin
            state_r <= ST_ACTIVE;
            // Losers that were waiting get one step older; the winner starts over.
            for (int i = 0; i < 4; i++) begin
              if (2'(i) == grant_phase_r) begin
                age_r[i] <= '0;
              end else if (pending_r[i] && (age_r[i] < AGE_W'(AGE_LIMIT))) begin
                age_r[i] <= age_r[i] + AGE_W'(1);
              end
            end
          end
        end
        ST_ACTIVE: begin
          if (bus.phase_done) begin
            state_r       <= ST_IDLE;
            grant_valid_r <= 1'b0;
            starve_flag_r <= 1'b0;
          end
        end
        ST_MAINT: begin
          if (!bus.maint_req) begin
            state_r       <= ST_IDLE;
            maintenance_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          grant_valid_r <= 1'b0;
          starve_flag_r <= 1'b0;
          maintenance_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_valid = grant_valid_r;
  assign bus.grant_phase = grant_phase_r;
  assign bus.pending     = pending_r;
  assign bus.starve_flag = starve_flag_r;
  assign bus.maintenance = maintenance_r;

endmodule
